// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic library's divide unit.
// Provides the divider state encoding, the default operand width and a
// helper that sizes the iteration counter for a given operand width.
package arith_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default operand/quotient/remainder width
  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to hold the value WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_restoring_4bit_if.sv
// Start/done handshake and operand/result bus of the divide unit.
// Signals:
//   start        request, sampled by the divider only in IDLE or DONE
//   dividend     unsigned dividend, sampled with an accepted start
//   divisor      unsigned divisor, sampled with an accepted start
//   busy         high while the divider iterates
//   done         one-cycle pulse, results valid in that cycle
//   quotient     registered quotient, held until the next accepted start
//   remainder    registered remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero
// Modports: master = requester side, slave = divider side.
interface divider_restoring_4bit_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational, WIDTH+1 bits wide.
// Ports:
//   a_shifted  partial remainder after the {A,Q} left shift
//   divisor    latched divisor D
//   a_next     partial remainder after the trial subtraction / restore
//   q_bit      quotient bit produced by this iteration
// The trial subtraction A - {0,D} is formed as A + ~{0,D} + 1 with a ripple
// of full adders, so a carry-out of 1 means "no borrow".
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   a_shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   a_next,
  output logic             q_bit
);

  logic [WIDTH:0] b_inv;
  logic [WIDTH:0] trial;
  logic           carry_out;

  assign b_inv = {1'b0, divisor} ^ {(WIDTH + 1){1'b1}};

  // Ripple-carry adder with carry-in 1 completes the two's complement subtract
  always_comb begin : ripple
    logic c;
    c     = 1'b1;
    trial = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      trial[i] = a_shifted[i] ^ b_inv[i] ^ c;
      c        = (a_shifted[i] & b_inv[i]) | (c & (a_shifted[i] ^ b_inv[i]));
    end
    carry_out = c;
  end

  // No borrow: keep the difference; borrow: restore the shifted value
  assign a_next = carry_out ? trial : a_shifted;
  assign q_bit  = carry_out;

endmodule

// File: rtl/divider_restoring_4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of divider_restoring_4bit_if (start/operands in,
//          busy/done/quotient/remainder/div_by_zero out)
// A nonzero-divisor request spends WIDTH cycles in RUN and then pulses done;
// a zero divisor goes straight to DONE with quotient all ones and
// remainder = dividend. Every output is driven straight from a flop.
module divider_restoring_4bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  divider_restoring_4bit_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic [WIDTH:0]   a_shifted;
  logic [WIDTH-1:0] q_shifted;
  logic [WIDTH:0]   a_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign zero_div  = (bus.divisor == '0);
  assign last_iter = (cnt_q == CNT_W'(1));

  // {A,Q} shifted left as one register pair; the MSB of A is always 0 here
  assign a_shifted = (a_q << 1) | (WIDTH + 1)'(q_q[WIDTH-1]);
  assign q_shifted = q_q << 1;
  assign q_next    = q_shifted | WIDTH'(q_bit);

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .a_shifted (a_shifted),
    .divisor   (d_q),
    .a_next    (a_next),
    .q_bit     (q_bit)
  );

  // State and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; start is ignored while iterating
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = zero_div ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic; busy/done are registered from the next state
  always_comb begin
    a_d         = a_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    if (accept) begin
      if (zero_div) begin
        quotient_d  = '1;
        remainder_d = bus.dividend;
        dbz_d       = 1'b1;
      end else begin
        d_d   = bus.divisor;
        a_d   = '0;
        q_d   = bus.dividend;
        cnt_d = CNT_W'(WIDTH);
        dbz_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      a_d   = a_next;
      q_d   = q_next;
      cnt_d = cnt_q - CNT_W'(1);
      if (last_iter) begin
        quotient_d  = q_next;
        remainder_d = a_next[WIDTH-1:0];
      end
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_restoring_4bit.sv
// Directed self-checking bench for divider_restoring_4bit (WIDTH = 4).
// Stimulus is driven one time unit after a rising edge and outputs are
// sampled at the same point, away from the active edge.
module tb_divider_restoring_4bit;

  localparam int W = 4;
  localparam int WAIT_LIMIT = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  divider_restoring_4bit_if #(.WIDTH(W)) bus_if ();

  divider_restoring_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports a failure with observed/expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a request for one edge; returns just after that edge (edge 0)
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    bus_if.start    = 1'b1;
    bus_if.dividend = dvd;
    bus_if.divisor  = dvs;
    @(posedge clk);
    #1;
    bus_if.start    = 1'b0;
  endtask

  // Bounded wait for done; counts edges waited and busy-high samples
  task automatic waitDone(output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = (bus_if.busy === 1'b1) ? 1 : 0;
    while (bus_if.done !== 1'b1 && cycles < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus_if.busy === 1'b1) busyCycles++;
    end
  endtask

  // Full request/response with result and latency checks; ends in the done cycle
  task automatic runDivision(input string tag, input logic [W-1:0] dvd,
                             input logic [W-1:0] dvs, input int expQ, input int expR,
                             input logic expZ, input int expLat, input int expBusy);
    int cycles;
    int busyCycles;
    applyStimulus(dvd, dvs);
    waitDone(cycles, busyCycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_done"}, 32'(bus_if.done), 32'd1);
    checkOutput({tag, "_busycycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({tag, "_quotient"}, 32'(bus_if.quotient), 32'(expQ));
    checkOutput({tag, "_remainder"}, 32'(bus_if.remainder), 32'(expR));
    checkOutput({tag, "_dbz"}, 32'(bus_if.div_by_zero), 32'(expZ));
  endtask

  initial begin
    int cycles;
    int busyCycles;
    int expQ;
    int expR;
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;

    // Reset state
    #3;
    checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("rst_done", 32'(bus_if.done), 32'd0);
    checkOutput("rst_quotient", 32'(bus_if.quotient), 32'd0);
    checkOutput("rst_remainder", 32'(bus_if.remainder), 32'd0);
    checkOutput("rst_dbz", 32'(bus_if.div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 13 / 3 and single-cycle done pulse
    runDivision("d13_3", 4'd13, 4'd3, 4, 1, 1'b0, 4, 4);
    @(posedge clk);
    #1;
    checkOutput("d13_3_done_pulse", 32'(bus_if.done), 32'd0);

    // 15 / 1, then 7 / 9, then results hold in IDLE
    runDivision("d15_1", 4'd15, 4'd1, 15, 0, 1'b0, 4, 4);
    @(posedge clk);
    #1;
    runDivision("d7_9", 4'd7, 4'd9, 0, 7, 1'b0, 4, 4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_quotient", 32'(bus_if.quotient), 32'd0);
    checkOutput("hold_remainder", 32'(bus_if.remainder), 32'd7);
    checkOutput("hold_done", 32'(bus_if.done), 32'd0);
    checkOutput("hold_busy", 32'(bus_if.busy), 32'd0);

    // Divide by zero, then a normal division clears the flag
    runDivision("d9_0", 4'd9, 4'd0, 15, 9, 1'b1, 0, 0);
    @(posedge clk);
    #1;
    runDivision("d8_2", 4'd8, 4'd2, 4, 0, 1'b0, 4, 4);
    @(posedge clk);
    #1;

    // start during RUN is ignored, then a back-to-back start from DONE
    applyStimulus(4'd14, 4'd4);
    @(posedge clk);
    #1;
    bus_if.start    = 1'b1;
    bus_if.dividend = 4'd5;
    bus_if.divisor  = 4'd5;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    waitDone(cycles, busyCycles);
    checkOutput("d14_4_latency", 32'(cycles), 32'd2);
    checkOutput("d14_4_quotient", 32'(bus_if.quotient), 32'd3);
    checkOutput("d14_4_remainder", 32'(bus_if.remainder), 32'd2);
    runDivision("b2b_5_5", 4'd5, 4'd5, 1, 0, 1'b0, 4, 4);

    // Reset asserted in the second RUN cycle aborts without a done
    applyStimulus(4'd12, 4'd5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("abort_done", 32'(bus_if.done), 32'd0);
    checkOutput("abort_quotient", 32'(bus_if.quotient), 32'd0);
    checkOutput("abort_remainder", 32'(bus_if.remainder), 32'd0);
    checkOutput("abort_dbz", 32'(bus_if.div_by_zero), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(bus_if.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runDivision("d10_3", 4'd10, 4'd3, 3, 1, 1'b0, 4, 4);

    // Every operand pair, issued back-to-back from each DONE cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        expQ = (b == 0) ? 15 : a / b;
        expR = (b == 0) ? a : a % b;
        runDivision($sformatf("ex_%0d_%0d", a, b), 4'(a), 4'(b), expQ, expR,
                    (b == 0), (b == 0) ? 0 : 4, (b == 0) ? 0 : 4);
        if (b != 0) begin
          checkOutput($sformatf("ex_%0d_%0d_invariant", a, b),
                      32'(int'(bus_if.quotient) * b + int'(bus_if.remainder)), 32'(a));
          checkOutput($sformatf("ex_%0d_%0d_rem_lt_div", a, b),
                      32'(int'(bus_if.remainder) < b), 32'd1);
        end
      end
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
